// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - SPI mode-0 LSB-first 32-bit frame master with valid/ready tx and available/ack rx
// Optional idle NOP polling is enabled by defining SPI_MASTER_AUTO_POLL_EN.
module spi_master_frame #(
  parameter int CLK_DIV     = 8,
  parameter int SS_SETUP    = 4,
  parameter int SS_HOLD     = 4,
  parameter int SS_GAP      = 8,
  parameter int POLL_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        rx_data_available,
  input  logic        rx_ack,
  output logic [31:0] rx_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] LP_DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] LP_SETUP_END = 8'(SS_SETUP - 1);
  localparam logic [7:0] LP_HOLD_END  = 8'(SS_HOLD - 1);
  localparam logic [7:0] LP_GAP_END   = 8'(SS_GAP - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [4:0]  r_bit;
  logic [4:0]  w_bit_nxt;
  logic [31:0] r_tx;
  logic [31:0] w_tx_nxt;
  logic [31:0] r_rx;
  logic [31:0] w_rx_nxt;
  logic [31:0] r_rx_data;
  logic [31:0] w_rx_data_nxt;
  logic        r_avail;
  logic        w_avail_nxt;
  logic        r_miso_q;
  logic        r_sck;
  logic        r_ss;
  logic        r_mosi;
  logic        r_tx_ready;
  logic        r_busy;
  logic        w_frame_active;
  logic        w_poll;

`ifdef SPI_MASTER_AUTO_POLL_EN
  logic [15:0] r_idle_cnt;

  assign w_poll = (r_state == S_IDLE) && !tx_valid && !r_avail &&
                  (r_idle_cnt == 16'(POLL_PERIOD));

  always_ff @(posedge clk) begin
    if (reset || (r_state != S_IDLE) || w_poll || (tx_valid && r_tx_ready)) begin
      r_idle_cnt <= '0;
    end else if (!tx_valid && !r_avail) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  assign w_poll = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 8'd1;
    w_bit_nxt     = r_bit;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_avail_nxt   = r_avail && !rx_ack;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        // A user frame takes priority over a poll triggering in the same cycle.
        if (tx_valid && r_tx_ready) begin
          w_tx_nxt    = tx_data;
          w_state_nxt = S_SETUP;
        end else if (w_poll) begin
          w_tx_nxt    = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == LP_SETUP_END) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (r_cnt == LP_DIV_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_cnt == LP_DIV_END) begin
          w_cnt_nxt = '0;
          w_rx_nxt  = {r_miso_q, r_rx[31:1]};
          w_tx_nxt  = {1'b0, r_tx[31:1]};
          if (r_bit == 5'd31) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_bit_nxt   = r_bit + 5'd1;
            w_state_nxt = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == LP_HOLD_END) begin
          w_cnt_nxt     = '0;
          w_rx_data_nxt = r_rx;
          w_avail_nxt   = 1'b1;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == LP_GAP_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they never glitch on decode.
  assign w_frame_active = (w_state_nxt == S_SETUP) || (w_state_nxt == S_LOW) ||
                          (w_state_nxt == S_HIGH)  || (w_state_nxt == S_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_avail    <= 1'b0;
      r_miso_q   <= 1'b0;
      r_sck      <= 1'b0;
      r_ss       <= 1'b1;
      r_mosi     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_avail    <= w_avail_nxt;
      r_miso_q   <= SPI_MISO;
      r_sck      <= (w_state_nxt == S_HIGH);
      r_ss       <= !w_frame_active;
      r_mosi     <= w_frame_active ? w_tx_nxt[0] : 1'b0;
      r_tx_ready <= (w_state_nxt == S_IDLE) && !w_avail_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign SPI_SCK           = r_sck;
  assign SPI_SS            = r_ss;
  assign SPI_MOSI          = r_mosi;
  assign tx_ready          = r_tx_ready;
  assign rx_data_available = r_avail;
  assign rx_data           = r_rx_data;
  assign busy              = r_busy;

endmodule

// File: tb/tb_spi_master_frame.sv
// tb/tb_spi_master_frame.sv - self-checking bench for spi_master_frame (CLK_DIV=4)
// Covers the SPI_MASTER_AUTO_POLL_EN build as well when that macro is defined.
module tb_spi_master_frame;

  localparam int CLK_DIV     = 4;
  localparam int SS_SETUP    = 4;
  localparam int SS_HOLD     = 4;
  localparam int SS_GAP      = 8;
  localparam int POLL_PERIOD = 64;
  localparam int FRAME_LOW   = SS_SETUP + 64 * CLK_DIV + SS_HOLD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = '0;
  logic        avail;
  logic        rx_ack = 1'b0;
  logic [31:0] rx_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_master_frame #(
    .CLK_DIV(CLK_DIV),
    .SS_SETUP(SS_SETUP),
    .SS_HOLD(SS_HOLD),
    .SS_GAP(SS_GAP),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SPI_SCK(sck),
    .SPI_SS(ss),
    .SPI_MOSI(mosi),
    .SPI_MISO(miso),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .rx_data_available(avail),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .busy(busy)
  );

  // Slave model: presents bit 0 on SS fall, next bit after each SCK fall; samples MOSI on SCK rise.
  logic [31:0] slave_word = '0;
  logic [31:0] mosi_cap = '0;
  logic        slave_miso = 1'b0;
  logic        loopback = 1'b1;
  logic        sck_q = 1'b0;
  logic        ss_q = 1'b1;
  int          slave_idx = 0;
  int          sck_rises = 0;

  assign miso = loopback ? mosi : slave_miso;

  always @(sck or ss) begin
    if (ss_q === 1'b1 && ss === 1'b0) begin
      slave_idx  = 0;
      slave_miso = slave_word[0];
      sck_rises  = 0;
      mosi_cap   = '0;
    end else if (sck_q === 1'b0 && sck === 1'b1) begin
      if (sck_rises < 32) mosi_cap[sck_rises] = mosi;
      sck_rises++;
    end else if (sck_q === 1'b1 && sck === 1'b0 && ss === 1'b0 && slave_idx < 31) begin
      slave_idx++;
      slave_miso = slave_word[slave_idx];
    end
    sck_q = sck;
    ss_q  = ss;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int t = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: tx_ready got 0, expected 1");
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Entered at the first sample with SS low; returns at the first sample with SS high.
  task automatic measure_frame(input string tag, input logic [31:0] exp_rx,
                               input logic [31:0] exp_mosi);
    int n = 0;
    while (!ss && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check({tag, " ss_low_cycles"}, 32'(n), 32'(FRAME_LOW));
    check({tag, " sck_rises"}, 32'(sck_rises), 32'd32);
    check({tag, " avail_at_ss_rise"}, 32'(avail), 32'd1);
    check({tag, " busy_in_gap"}, 32'(busy), 32'd1);
    check({tag, " rx_data"}, rx_data, exp_rx);
    check({tag, " mosi_bits"}, mosi_cap, exp_mosi);
  endtask

  task automatic ack_now(input string tag);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check({tag, " avail_after_ack"}, 32'(avail), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0] tx;
    logic        lb;
    logic [31:0] slave;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad;
    int h;
    int r;
    vecs[0] = '{tx: 32'hCAFE7701, lb: 1'b1, slave: 32'h00000000, exp_rx: 32'hCAFE7701};
    vecs[1] = '{tx: 32'h12345678, lb: 1'b0, slave: 32'h00A5A560, exp_rx: 32'h00A5A560};
    vecs[2] = '{tx: 32'h80000001, lb: 1'b1, slave: 32'h00000000, exp_rx: 32'h80000001};
    vecs[3] = '{tx: 32'h00000000, lb: 1'b0, slave: 32'hFFFF0001, exp_rx: 32'hFFFF0001};

    repeat (3) @(negedge clk);
    check("reset ss", 32'(ss), 32'd1);
    check("reset sck", 32'(sck), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd0);
    check("reset avail", 32'(avail), 32'd0);
    check("reset rx_data", rx_data, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("tx_ready after reset", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      loopback   = vecs[i].lb;
      slave_word = vecs[i].slave;
      send(vecs[i].tx);
      check($sformatf("v%0d ss_after_handshake", i), 32'(ss), 32'd0);
      check($sformatf("v%0d mosi_first_bit", i), 32'(mosi), 32'(vecs[i].tx[0]));
      check($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      measure_frame($sformatf("v%0d", i), vecs[i].exp_rx, vecs[i].tx);
      ack_now($sformatf("v%0d", i));
    end

    // Unacked result blocks the next frame until rx_ack.
    loopback = 1'b1;
    send(32'hA5A50F0F);
    measure_frame("noack_first", 32'hA5A50F0F, 32'hA5A50F0F);
    tx_valid = 1'b1;
    tx_data  = 32'h00000002;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!ss || tx_ready) bad++;
    end
    check("noack blocked_cycles", 32'(bad), 32'd0);
    check("noack avail_held", 32'(avail), 32'd1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("noack avail_cleared", 32'(avail), 32'd0);
    check("noack tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("noack second_start", 32'(ss), 32'd0);
    measure_frame("noack_second", 32'h00000002, 32'h00000002);
    ack_now("noack_second");

    // tx_valid held during GAP: next SS fall only after the gap plus one IDLE cycle.
    send(32'h0F0F1234);
    measure_frame("gap_first", 32'h0F0F1234, 32'h0F0F1234);
    rx_ack   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 32'h55AA33CC;
    h = 0;
    r = 0;
    while (ss && h < 100) begin
      h++;
      if (tx_ready) r++;
      @(negedge clk);
      rx_ack = 1'b0;
    end
    tx_valid = 1'b0;
    check("gap ss_high_cycles", 32'(h), 32'(SS_GAP + 1));
    check("gap tx_ready_cycles", 32'(r), 32'd1);
    measure_frame("gap_second", 32'h55AA33CC, 32'h55AA33CC);
    ack_now("gap_second");

    // Reset during the 10th SCK high phase aborts the frame.
    send(32'hFFFFFFFF);
    h = 0;
    while (sck_rises < 10 && h < 1000) begin
      @(negedge clk);
      h++;
    end
    check("midreset sck_high", 32'(sck), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset ss", 32'(ss), 32'd1);
    check("midreset sck", 32'(sck), 32'd0);
    check("midreset avail", 32'(avail), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset rx_data", rx_data, 32'd0);
    reset = 1'b0;
    send(32'h00000001);
    measure_frame("after_reset", 32'h00000001, 32'h00000001);
    ack_now("after_reset");

`ifdef SPI_MASTER_AUTO_POLL_EN
    h = 0;
    while (ss && h < POLL_PERIOD + 40) begin
      @(negedge clk);
      h++;
    end
    check("poll started", 32'(ss), 32'd0);
    check("poll tx_ready", 32'(tx_ready), 32'd0);
    measure_frame("poll", 32'h00000000, 32'h00000000);
    ack_now("poll");
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_frame.md
Name: spi_master_frame

Overview:
- SPI master (mode 0, LSB-first) that drives 32-bit frames to the FPGA-side SPI slave block: opcode/status byte plus three data bytes.
- Used on the host-emulation/test side and for board-to-board links.
- Accepts a 32-bit word on a valid/ready handshake, shifts it out on MOSI and captures 32 MISO bits at the same time.
- Presents the received word with an available/ack handshake, mirroring the slave's read interface.

Parameters:
- CLK_DIV, 8: clk cycles per SCK half-period; legal range 4..255.
- SS_SETUP, 4: clk cycles SS is low before the first SCK low phase.
- SS_HOLD, 4: clk cycles after the last SCK falling edge before SS rises.
- SS_GAP, 8: minimum clk cycles SS stays high between frames.
- POLL_PERIOD, 1024: idle cycles before an automatic NOP frame (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- SPI_SCK  output  1  serial clock; idles low
- SPI_SS  output  1  slave select, active low
- SPI_MOSI  output  1  serial data out, LSB first
- SPI_MISO  input  1  serial data in, LSB first
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  master can accept a frame
- tx_data  input  32  frame to send; bits[7:0] = opcode
- rx_data_available  output  1  rx_data holds an unread frame
- rx_ack  input  1  consumer has read rx_data
- rx_data  output  32  last received frame; bit0 = first bit received
- busy  output  1  a frame is in progress (SS low or in gap)

Behaviour:
- Interface: one clock domain, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: SPI_SCK=0, SPI_SS=1, SPI_MOSI=0, tx_ready=0 (rises the cycle after reset deasserts), rx_data_available=0, rx_data=0, busy=0, FSM=IDLE.
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - tx_ready = 1 only when rx_data_available=0. The master never starts a frame while an unread result is pending, so results are never lost.
  - On tx_valid&tx_ready in cycle T: latch tx_data into the shift register, go to SETUP.
  - In T+1: SS=0, MOSI=tx_data[0], busy=1.
- SETUP: hold for SS_SETUP cycles, then go to LOW with bit index 0.
- LOW:
  - SCK=0 and MOSI=current bit, for CLK_DIV cycles.
  - Then go to HIGH.
- HIGH:
  - SCK=1 for CLK_DIV cycles.
  - On the last HIGH cycle, SPI_MISO (through one input register) is shifted in at the MSB of the rx shift register, which shifts right. After 32 bits, the first bit is at bit0.
  - Then SCK=0 and the tx shift register moves right by one.
  - If the bit index is 31, go to HOLD; otherwise increment the index and go to LOW.
- Exactly 32 SCK rising edges per frame. MOSI changes only while SCK is low, at least CLK_DIV cycles before the rising edge.
- HOLD:
  - After SS_HOLD cycles: SS=1, MOSI=0, rx_data=rx shift register, rx_data_available=1 (all in the same cycle).
  - Then go to GAP.
- GAP: wait SS_GAP cycles, then go to IDLE; busy=0 on entry to IDLE.
- rx_ack: when rx_ack=1 and rx_data_available=1, rx_data_available clears the next cycle. rx_ack while rx_data_available=0 is ignored.
- Back-to-back tx_valid: the next frame starts no earlier than the first IDLE cycle after GAP, and only if rx has been acked.
- Frame length in clk cycles, handshake to SS rise: 1 + SS_SETUP + 64*CLK_DIV + SS_HOLD.
- tx_valid while tx_ready=0: no effect. The caller holds tx_valid and tx_data.
- Reset mid-frame:
  - Next cycle SS=1, SCK=0, FSM=IDLE.
  - The partial rx frame is discarded; rx_data_available=0.
- Slave status decoding (write-ok, data-available bits) is not done here; the consumer interprets rx_data.

Optional Feature:
- Macro: SPI_MASTER_AUTO_POLL_EN.
- Enabled:
  - An idle counter increments in IDLE while tx_valid=0 and rx_data_available=0.
  - When it reaches POLL_PERIOD, the master sends a frame of 32'h00000000 (NOP) exactly like a user frame.
  - The counter clears on any frame start.
  - tx_ready is 0 while a poll frame runs.
  - A simultaneous tx_valid wins over the poll.
  - The poll result is delivered on rx_data/rx_data_available like any frame.
- Disabled: no counter logic; frames start only from tx_valid.

Test Plan:
- CLK_DIV=4, MISO looped to MOSI, send 32'hCAFE7701 → exactly 32 SCK rising edges; SS low for 1+4+256+4-1 cycles; rx_data=32'hCAFE7701; rx_data_available=1 in the SS-rise cycle.
- MISO driven from a model of the slave emitting 32'h00A5A560 LSB-first on SCK rising edges → rx_data=32'h00A5A560; MOSI sampled by the model on SCK rising edges equals tx_data bit by bit, LSB first.
- Don't ack the first result, hold tx_valid with 32'h00000002 → tx_ready=0, SS stays 1; pulse rx_ack → rx_data_available=0 next cycle; the second frame starts after that.
- Reset asserted on the 10th SCK high phase → next cycle SS=1, SCK=0, rx_data_available=0; a following frame 32'h00000001 completes correctly.
- SPI_MASTER_AUTO_POLL_EN with POLL_PERIOD=64, idle bus → a NOP frame (MOSI all 0) starts after 64 idle cycles; tx_valid in the trigger cycle sends the user frame instead.
- tx_valid asserted during GAP → no frame until IDLE; SS stays high for at least SS_GAP cycles between frames.
